parity_error_logger: RTL

- Downstream consumer of the parity-checked memory fetch stage.
- Watches the {address, data, parity, check-result} stream during a scan of all 2^ADDR_W addresses.
- Counts words checked and parity failures, and captures each failing word into a small first-word-fall-through FIFO that a host can drain.
- Reports scan completion and pass/fail.

---
 rtl/parity_error_logger.sv | 132 +++++++++++++
 1 files changed

// File: rtl/parity_error_logger.sv
// Parity error logger: counts words and parity failures during an address scan and
// captures failing words in a fall-through FIFO. Optional PARITY_RECHECK_EN adds checker_fault.
module parity_error_logger #(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [7:0]        in_data,
   input  logic              in_parity,
   input  logic              in_ok,
   input  logic              rd_en,
   output logic [ADDR_W+8:0] rd_data,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              overflow,
   output logic [CNT_W-1:0]  word_count,
   output logic [CNT_W-1:0]  err_count,
   output logic              busy,
   output logic              scan_done,
   output logic              scan_pass,
`ifdef PARITY_RECHECK_EN
   output logic              checker_fault,
`endif
   output logic [1:0]        fsm_state
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = ADDR_W + 9;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [1:0]         state;
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W:0]     count;

   logic restart;
   logic accept;
   logic push_req;
   logic pop;
   logic do_push;
   logic last_word;

   // Handshake: a word is consumed on any rising edge with in_valid=1 while SCAN;
   // there is no back-pressure. A pop happens on rd_en=1 only when the FIFO is non-empty.
   assign restart   = start && (state != SCAN);
   assign accept    = (state == SCAN) && in_valid;
   assign push_req  = accept && !in_ok;
   assign pop       = rd_en && !fifo_empty;
   assign do_push   = push_req && (!fifo_full || pop);
   assign last_word = accept && (in_addr == {ADDR_W{1'b1}});

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_CNT);
   assign rd_data    = fifo_empty ? '0 : mem[rd_ptr];
   assign busy       = (state == SCAN);
   assign scan_done  = (state == DONE);
   assign scan_pass  = (state == DONE) && (err_count == '0);
   assign fsm_state  = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state <= SCAN;
            SCAN:    if (last_word) state <= DONE;
            DONE:    if (start) state <= SCAN;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_count <= '0;
         err_count  <= '0;
      end else if (restart) begin
         word_count <= '0;
         err_count  <= '0;
      end else if (accept) begin
         if (word_count != {CNT_W{1'b1}}) word_count <= word_count + CNT_W'(1);
         if (!in_ok && (err_count != {CNT_W{1'b1}})) err_count <= err_count + CNT_W'(1);
      end
   end

   // Clearing on restart takes priority over any read issued in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (restart) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !pop) count <= count + (PTR_W+1)'(1);
         else if (pop && !do_push) count <= count - (PTR_W+1)'(1);
         if (push_req && !do_push) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !restart) mem[wr_ptr] <= {in_addr, in_data, in_parity};
   end

`ifdef PARITY_RECHECK_EN
   logic recheck_bad;
   assign recheck_bad = ((^in_data) == in_parity) != in_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) checker_fault <= 1'b0;
      else if (restart) checker_fault <= 1'b0;
      else if (accept && recheck_bad) checker_fault <= 1'b1;
   end
`endif

endmodule
